// File: rtl/fp_alu_pkg.sv
// ============================================================================
// Module   : fp_alu_pkg
// Purpose  : Opcodes, qNaN constant, request record and FSM encoding shared
//            by the fp_alu issue stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_alu_pkg;

    localparam logic [5:0] c_op_nop  = 6'd0;
    localparam logic [5:0] c_op_add  = 6'd1;
    localparam logic [5:0] c_op_sub  = 6'd2;
    localparam logic [5:0] c_op_mul  = 6'd3;
    localparam logic [5:0] c_op_div  = 6'd4;
    localparam logic [5:0] c_op_sqrt = 6'd5;
    localparam logic [5:0] c_op_cmp  = 6'd6;
    localparam logic [5:0] c_op_cvt  = 6'd7;

    localparam logic [31:0] c_qnan = 32'h7FC0_0000;

    localparam int c_req_w = 74;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
    } req_t;

    typedef enum logic [2:0] {
        c_st_idle  = 3'd0,
        c_st_issue = 3'd1,
        c_st_wait  = 3'd2,
        c_st_flush = 3'd3,
        c_st_hold  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fp_req_fifo.sv
// ============================================================================
// Module   : fp_req_fifo
// Purpose  : Power-of-two request FIFO; head is visible while not empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 74
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w:0]   c_full_cnt = (c_ptr_w + 1)'(DEPTH);
    localparam logic [c_ptr_w:0]   c_cnt_one  = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign full      = (r_count == c_full_cnt);
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/fp_alu_issue.sv
// ============================================================================
// Module   : fp_alu_issue
// Purpose  : Queues fp_alu requests, issues them one at a time with timeout
//            recovery, and returns in-order tagged responses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_alu_issue
    import fp_alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [3:0]  req_tag,
    output logic        alu_ce,
    output logic        alu_sclr,
    output logic [5:0]  alu_operation,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic        alu_rdy,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_tag,
    output logic        rsp_err,
    output logic        busy,
    output logic        timeout_err
);

    localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_alu_ce;
    logic                r_alu_sclr;
    logic [5:0]          r_op;
    logic [31:0]         r_a;
    logic [31:0]         r_b;
    logic [3:0]          r_tag;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_result;
    logic [3:0]          r_rsp_tag;
    logic                r_rsp_err;
    logic                r_timeout_err;

    logic [c_req_w-1:0]  w_head_raw;
    req_t                w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;

    fp_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_req_w)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_valid),
        .push_data ({req_op, req_a, req_b, req_tag}),
        .pop       (w_pop),
        .head      (w_head_raw),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign w_head = w_head_raw;

    // Pops only from IDLE or on the HOLD handshake, both decoded from registered state.
    assign w_pop = !w_empty &&
                   ((r_state == c_st_idle) || ((r_state == c_st_hold) && rsp_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_cnt         <= '0;
            r_alu_ce      <= 1'b0;
            r_alu_sclr    <= 1'b0;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_tag         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_tag     <= '0;
            r_rsp_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_pop) begin
                r_op  <= w_head.op;
                r_a   <= w_head.a;
                r_b   <= w_head.b;
                r_tag <= w_head.tag;
            end
            case (r_state)
                c_st_idle: begin
                    if (!w_empty) r_state <= c_st_issue;
                end
                c_st_issue: begin
                    r_alu_ce <= 1'b1;
                    r_cnt    <= '0;
                    r_state  <= c_st_wait;
                end
                c_st_wait: begin
                    if (alu_rdy) begin
                        r_rsp_result <= alu_result;
                        r_rsp_tag    <= r_tag;
                        r_rsp_err    <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_alu_ce     <= 1'b0;
                        r_state      <= c_st_hold;
                    end else if (r_cnt == c_cnt_last) begin
                        r_alu_ce   <= 1'b0;
                        r_alu_sclr <= 1'b1;
                        r_state    <= c_st_flush;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_st_flush: begin
                    r_alu_sclr    <= 1'b0;
                    r_rsp_result  <= c_qnan;
                    r_rsp_tag     <= r_tag;
                    r_rsp_err     <= 1'b1;
                    r_rsp_valid   <= 1'b1;
                    r_timeout_err <= 1'b1;
                    r_state       <= c_st_hold;
                end
                c_st_hold: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= w_empty ? c_st_idle : c_st_issue;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign req_ready     = !w_full;
    assign busy          = !w_empty || (r_state != c_st_idle);
    assign alu_ce        = r_alu_ce;
    assign alu_sclr      = r_alu_sclr;
    assign alu_operation = r_op;
    assign alu_a         = r_a;
    assign alu_b         = r_b;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_result    = r_rsp_result;
    assign rsp_tag       = r_rsp_tag;
    assign rsp_err       = r_rsp_err;
    assign timeout_err   = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_fp_alu_issue.sv
// ============================================================================
// Module   : tb_fp_alu_issue
// Purpose  : Self-checking bench for fp_alu_issue with an fp_alu stand-in and
//            an in-order response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_alu_issue;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_tag;
    logic        alu_ce, alu_sclr;
    logic [5:0]  alu_operation;
    logic [31:0] alu_a, alu_b;
    logic        alu_rdy;
    logic [31:0] alu_result;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_tag;
    logic        rsp_err, busy, timeout_err;

    fp_alu_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_ce(alu_ce), .alu_sclr(alu_sclr), .alu_operation(alu_operation),
        .alu_a(alu_a), .alu_b(alu_b), .alu_rdy(alu_rdy), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        err;
    } rsp_t;

    int           checks = 0;
    int           errors = 0;
    rsp_t         exp_q[$];
    logic [69:0]  iss_q[$];
    bit           dead = 0, spur = 0;
    int           fixed_lat = 0, lat = 1, stub_cnt = 0;
    int           cyc = 0, ce_rise_cyc = 0, acc_cyc = 0, valid_rise_cyc = 0;
    int           acc_cnt = 0, resp_seen = 0, sclr_cnt = 0;
    bit           prev_ce = 0, prev_sclr = 0, prev_hold = 0, prev_valid = 0;
    rsp_t         prev_rsp, last_rsp;

    // Stand-in fp_alu: knows the directed 10.0 + 50.0 sum, otherwise a fixed mixing function.
    function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 6'd1 && a == 32'h4120_0000 && b == 32'h4248_0000) return 32'h4270_0000;
        return (a ^ {b[15:0], b[31:16]}) + {26'd0, op};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [112:0] out_vec();
        return {req_ready, alu_ce, alu_sclr, alu_operation, alu_a, alu_b,
                rsp_valid, rsp_result, rsp_tag, rsp_err, busy, timeout_err};
    endfunction

    // One clock: check observations of the current cycle, drive the ALU stand-in, advance.
    task automatic cycle();
        rsp_t cur;
        cur = {rsp_result, rsp_tag, rsp_err};
        chk("busy", busy, exp_q.size() != 0);
        if (prev_hold) chk("rsp_stable", {rsp_valid, cur}, {1'b1, prev_rsp});
        if (rsp_valid && !prev_valid) valid_rise_cyc = cyc;
        if (rsp_valid && rsp_ready) begin
            chk("rsp_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("rsp_payload", cur, exp_q.pop_front());
            last_rsp = cur;
            resp_seen++;
        end
        prev_hold  = rsp_valid && !rsp_ready;
        prev_valid = rsp_valid;
        prev_rsp   = cur;
        if (alu_ce && !prev_ce) begin
            chk("issue_pending", iss_q.size() != 0, 1);
            if (iss_q.size() != 0) chk("issue_operands", {alu_operation, alu_a, alu_b}, iss_q.pop_front());
            ce_rise_cyc = cyc;
            stub_cnt    = 0;
            lat         = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
        end
        if (alu_ce) chk("ce_while_rsp_valid", rsp_valid, 0);
        if (alu_sclr) chk("sclr_width", prev_sclr, 0);
        if (alu_sclr && !prev_sclr) begin
            chk("sclr_delay", cyc - ce_rise_cyc, TIMEOUT);
            sclr_cnt++;
        end
        if (req_valid && req_ready) begin
            exp_q.push_back(dead ? rsp_t'({32'h7FC0_0000, req_tag, 1'b1})
                                 : rsp_t'({alu_fn(req_op, req_a, req_b), req_tag, 1'b0}));
            iss_q.push_back({req_op, req_a, req_b});
            acc_cyc = cyc;
            acc_cnt++;
        end
        prev_ce   = alu_ce;
        prev_sclr = alu_sclr;
        if (alu_ce) begin
            stub_cnt++;
            if (!dead && stub_cnt == lat) begin
                alu_rdy    = 1'b1;
                alu_result = alu_fn(alu_operation, alu_a, alu_b);
            end else begin
                alu_rdy    = 1'b0;
                alu_result = $urandom;
            end
        end else begin
            alu_rdy    = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            alu_result = $urandom;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        bit done;
        done      = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        for (int i = 0; i < 300 && !done; i++) begin
            done = req_ready;
            cycle();
        end
        req_valid = 1'b0;
        chk("send_accepted", done, 1);
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && (exp_q.size() != 0 || busy); i++) cycle();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit fired;
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        alu_rdy = 1'b0; alu_result = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", out_vec(), {1'b1, 112'd0});
        rst_n = 1'b1;

        // Single directed operation with minimum ALU latency.
        fixed_lat = 1; rsp_ready = 1'b1; resp_seen = 0;
        send(6'd1, 32'h4120_0000, 32'h4248_0000, 4'd3);
        drain(100);
        chk("single_count", resp_seen, 1);
        chk("single_result", last_rsp, {32'h4270_0000, 4'd3, 1'b0});
        chk("single_latency", valid_rise_cyc - acc_cyc, 3 + 1);

        // Random traffic with random backpressure, latency and spurious alu_rdy.
        spur = 1; fixed_lat = 0; acc_cnt = 0; resp_seen = 0;
        for (int i = 0; i < 400; i++) begin
            rsp_ready = ($urandom_range(0, 9) < 7);
            if (!req_valid && $urandom_range(0, 1) == 1) begin
                req_valid = 1'b1;
                req_op    = 6'($urandom_range(1, 8));
                req_a     = $urandom;
                req_b     = $urandom;
                req_tag   = 4'($urandom);
            end
            fired = req_valid && req_ready;
            cycle();
            if (fired) req_valid = 1'b0;
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        drain(400);
        chk("random_count", resp_seen, acc_cnt);

        // Burst of five against a slow ALU: FIFO fills behind the operand register.
        spur = 0; fixed_lat = 40; acc_cnt = 0;
        req_valid = 1'b1; req_op = 6'd2; req_tag = 4'd0; req_a = $urandom; req_b = $urandom;
        for (int i = 0; i < 20 && acc_cnt < 5; i++) begin
            fired = req_ready;
            cycle();
            if (fired) begin req_tag = req_tag + 4'd1; req_a = $urandom; req_b = $urandom; end
        end
        chk("burst_accepted", acc_cnt, 5);
        chk("burst_full", req_ready, 0);
        cycle();
        req_valid = 1'b0;
        drain(600);

        // Response backpressure with spurious alu_rdy during HOLD.
        spur = 1; fixed_lat = 2; rsp_ready = 1'b0;
        send(6'd3, $urandom, $urandom, 4'hA);
        send(6'd4, $urandom, $urandom, 4'hB);
        for (int i = 0; i < 50 && !rsp_valid; i++) cycle();
        chk("bp_valid", rsp_valid, 1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("bp_no_issue", alu_ce, 0);
        end
        rsp_ready = 1'b1;
        drain(200);
        for (int i = 0; i < 10; i++) cycle();
        spur = 0;

        // Timeout: the ALU never answers.
        dead = 1; fixed_lat = 0; sclr_cnt = 0;
        send(6'd5, $urandom, $urandom, 4'h7);
        drain(400);
        chk("timeout_sclr_pulses", sclr_cnt, 1);
        chk("timeout_err_set", timeout_err, 1);
        dead = 0;
        send(6'd1, $urandom, $urandom, 4'h8);
        drain(100);
        chk("timeout_err_sticky", timeout_err, 1);

        // Reset mid-WAIT with three operations queued.
        fixed_lat = 50;
        for (int k = 0; k < 4; k++) send(6'd6, $urandom, $urandom, 4'(k));
        cycle(); cycle();
        chk("pre_reset_ce", alu_ce, 1);
        rst_n = 1'b0;
        #1;
        chk("midwait_reset_outputs", out_vec(), {1'b1, 112'd0});
        exp_q.delete(); iss_q.delete();
        prev_ce = 0; prev_sclr = 0; prev_hold = 0; prev_valid = 0; alu_rdy = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1; resp_seen = 0;
        for (int i = 0; i < 20; i++) cycle();
        chk("reset_no_rsp", resp_seen, 0);
        fixed_lat = 3;
        send(6'd1, 32'h4120_0000, 32'h4248_0000, 4'd9);
        drain(100);
        chk("post_reset_count", resp_seen, 1);
        chk("post_reset_result", last_rsp, {32'h4270_0000, 4'd9, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp_alu_issue.md
FP_ALU_ISSUE -- requirements
Module: fp_alu_issue

Interface
REQ-001 Parameter DEPTH, 4, request FIFO entries (power of two, >= 2).
REQ-002 Parameter TIMEOUT, 64, maximum cycles to wait for alu_rdy per operation.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  request present; req_ready  out  1  request accepted when both high.
REQ-006 req_op  in  6  operation code; req_a, req_b  in  32  IEEE-754 single operands; req_tag  in  4  caller tag.
REQ-007 alu_ce  out  1; alu_sclr  out  1; alu_operation  out  6; alu_a, alu_b  out  32: drive the fp_alu.
REQ-008 alu_rdy  in  1; alu_result  in  32: result return from the fp_alu.
REQ-009 rsp_valid  out  1; rsp_ready  in  1; rsp_result  out  32; rsp_tag  out  4; rsp_err  out  1: response channel.
REQ-010 busy  out  1  high when FIFO non-empty or FSM not IDLE; timeout_err  out  1  sticky timeout flag.

Function
REQ-011 FIFO SHALL store {op, a, b, tag}; req_ready SHALL equal not-full, registered-free (combinational from count).
REQ-012 A push when full SHALL be impossible (req_ready low); simultaneous push and pop when full SHALL not occur because pop is registered.
REQ-013 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-014 FSM states: IDLE, ISSUE, WAIT, FLUSH, HOLD.
REQ-015 IDLE: FIFO non-empty -> pop head into operand register, go ISSUE next cycle.
REQ-016 ISSUE: alu_ce=1, operand register driven on alu_a/alu_b/alu_operation, timeout counter cleared; next state WAIT.
REQ-017 WAIT: alu_ce held 1 and operands held stable; alu_rdy=1 -> capture alu_result, tag, err=0 into response register, rsp_valid=1, alu_ce=0 next cycle, go HOLD.
REQ-018 WAIT: counter reaches TIMEOUT-1 without alu_rdy -> go FLUSH.
REQ-019 FLUSH: alu_sclr=1, alu_ce=0 for exactly one cycle; response register loaded with 32'h7FC00000, current tag, err=1; timeout_err set; go HOLD.
REQ-020 HOLD: rsp_valid=1 with stable payload until rsp_ready=1; on handshake go IDLE, or directly ISSUE (with pop) if FIFO non-empty.
REQ-021 alu_rdy outside WAIT SHALL be ignored.
REQ-022 Minimum latency accept -> rsp_valid: 3 cycles plus fp_alu latency (push N, pop N+1, ISSUE N+2, WAIT from N+3).
REQ-023 Responses SHALL return in request order; exactly one response per accepted request.
REQ-024 timeout_err SHALL remain set until reset.

Reset
REQ-025 rst_n low SHALL asynchronously clear FIFO pointers/count, FSM to IDLE, counter to 0.
REQ-026 Reset values: req_ready=1, alu_ce=0, alu_sclr=0, alu_operation=0, alu_a=0, alu_b=0, rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_err=0, busy=0, timeout_err=0.
REQ-027 Reset during WAIT/HOLD SHALL discard in-flight and queued operations without a response.

Structure
REQ-028 Shared package fp_alu_pkg SHALL hold the 6-bit opcode constants, the 32-bit qNaN constant and the FSM state encoding.
REQ-029 FIFO SHALL be a separate sub-module fp_req_fifo (parameter DEPTH, width 74).

Verification
REQ-030 Single op: op=1, a=32'h41200000, b=32'h42480000, tag=3, rsp_ready=1 -> one response, rsp_result=32'h42700000, rsp_tag=3, rsp_err=0.
REQ-031 Burst of 5 back-to-back requests, DEPTH=4, ALU stalled -> req_ready low after 4 accepted (plus one in operand register), all 5 responses returned in tag order.
REQ-032 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and payload stable, no new alu_ce pulse until handshake.
REQ-033 Timeout: alu_rdy tied 0 -> alu_sclr one-cycle pulse 64 cycles after ISSUE, response 32'h7FC00000 with rsp_err=1, timeout_err=1 thereafter.
REQ-034 Reset mid-WAIT: rst_n low 1 cycle with 3 queued -> all outputs at reset values, no responses emitted, next request processed normally.
REQ-035 Spurious alu_rdy in IDLE/HOLD -> no state or payload change.
